// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with registered or fall-through read
module param_sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write,
    input  logic [DATA_W-1:0]          din,
    input  logic                       read,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("param_sync_fifo: AF_THRESH out of range 0..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
        $error("param_sync_fifo: AE_THRESH out of range 0..DEPTH");
    end
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    assign fifo_full    = (level == LW'(DEPTH));
    assign fifo_empty   = (level == '0);
    assign almost_full  = (level >= LW'(AF_THRESH));
    assign almost_empty = (level <= LW'(AE_THRESH));

    // Full blocks only the write and empty blocks only the read, so a
    // simultaneous request pair always makes progress on one side.
    assign wr_acc = write & ~fifo_full;
    assign rd_acc = read  & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // A new error wins over clr_err so no event can be lost in the clearing cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write & fifo_full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (read & fifo_empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    if (FWFT == 0) begin : g_registered
        logic [DATA_W-1:0] dout_q;
        logic              dout_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_valid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end else begin : g_fall_through
        // Masked while empty so stale or uninitialised memory never reaches dout.
        assign dout       = fifo_empty ? '0 : mem[rd_ptr];
        assign dout_valid = ~fifo_empty;
    end
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - directed self-checking bench for param_sync_fifo
module tb_param_sync_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       write, read, clr_err;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid, fifo_full, fifo_empty, almost_full, almost_empty;
    logic [3:0] level;
    logic       overflow, underflow;

    logic       f_write, f_read, f_clr_err;
    logic [7:0] f_din;
    logic [7:0] f_dout;
    logic       f_dout_valid, f_full, f_empty, f_af, f_ae;
    logic [3:0] f_level;
    logic       f_overflow, f_underflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_W(8), .DEPTH(8), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .write(write), .din(din), .read(read), .clr_err(clr_err),
        .dout(dout), .dout_valid(dout_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    param_sync_fifo #(.DATA_W(8), .DEPTH(8), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .write(f_write), .din(f_din), .read(f_read), .clr_err(f_clr_err),
        .dout(f_dout), .dout_valid(f_dout_valid), .fifo_full(f_full), .fifo_empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; write = 0; read = 0; clr_err = 0; din = '0;
        f_write = 0; f_read = 0; f_clr_err = 0; f_din = '0;
        tick();
        rst = 1'b0;
        check("rst_level", 32'(level), 0);
        check("rst_empty", 32'(fifo_empty), 1);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_dout", 32'(dout), 0);
        check("rst_dv", 32'(dout_valid), 0);
        check("rst_errs", 32'({overflow, underflow}), 0);
        check("fwft_rst_dv", 32'(f_dout_valid), 0);

        // 1: eight writes up to full
        for (int i = 1; i <= 8; i++) begin
            write = 1; din = 8'(i);
            tick();
            check($sformatf("t1_level%0d", i), 32'(level), 32'(i));
            check($sformatf("t1_af%0d", i), 32'(almost_full), (i >= 6) ? 1 : 0);
        end
        write = 0;
        check("t1_full", 32'(fifo_full), 1);

        // 2: drain, registered read data arrives one cycle after each read
        for (int i = 1; i <= 8; i++) begin
            read = 1;
            tick();
            check($sformatf("t2_dout%0d", i), 32'(dout), 32'(i));
            check($sformatf("t2_dv%0d", i), 32'(dout_valid), 1);
        end
        read = 0;
        tick();
        check("t2_dv_drop", 32'(dout_valid), 0);
        check("t2_dout_hold", 32'(dout), 8);
        check("t2_empty", 32'(fifo_empty), 1);
        check("t2_errs", 32'({overflow, underflow}), 0);

        // 3: level 4, then ten simultaneous read+write cycles across pointer wrap
        for (int i = 0; i < 4; i++) begin
            write = 1; din = 8'(8'h10 + i);
            tick();
        end
        check("t3_level_pre", 32'(level), 4);
        for (int k = 0; k < 10; k++) begin
            write = 1; read = 1; din = 8'(8'h14 + k);
            tick();
            check($sformatf("t3_level%0d", k), 32'(level), 4);
            check($sformatf("t3_dout%0d", k), 32'(dout), 32'(8'h10 + k));
        end
        write = 0; read = 0;

        // 4: fill (contents 0x1A..0x21), overflow, clear, drain, underflow
        for (int i = 0; i < 4; i++) begin
            write = 1; din = 8'(8'h1E + i);
            tick();
        end
        check("t4_full", 32'(fifo_full), 1);
        tick();
        write = 0;
        check("t4_ovf", 32'(overflow), 1);
        check("t4_ovf_level", 32'(level), 8);
        clr_err = 1;
        tick();
        clr_err = 0;
        check("t4_ovf_clr", 32'(overflow), 0);
        for (int i = 0; i < 8; i++) begin
            read = 1;
            tick();
            check($sformatf("t4_dout%0d", i), 32'(dout), 32'(8'h1A + i));
        end
        check("t4_empty", 32'(fifo_empty), 1);
        tick();
        read = 0;
        check("t4_unf", 32'(underflow), 1);
        check("t4_unf_level", 32'(level), 0);
        read = 1; clr_err = 1;
        tick();
        read = 0;
        check("t4_unf_set_clr", 32'(underflow), 1);
        tick();
        clr_err = 0;
        check("t4_unf_clr", 32'(underflow), 0);
        write = 1; din = 8'h40;
        tick();
        tick(); tick(); tick(); tick(); tick(); tick(); tick();
        clr_err = 1;
        tick();
        write = 0; clr_err = 0;
        check("t4_ovf_set_clr", 32'(overflow), 1);
        clr_err = 1;
        tick();
        clr_err = 0;
        check("t4_ovf_clr2", 32'(overflow), 0);
        for (int i = 0; i < 8; i++) begin
            read = 1;
            tick();
        end
        read = 0;
        check("t4_drained", 32'(level), 0);

        // 5: fall-through instance
        f_write = 1; f_din = 8'hA5;
        tick();
        f_write = 0;
        check("t5_dout", 32'(f_dout), 32'h A5);
        check("t5_dv", 32'(f_dout_valid), 1);
        f_read = 1;
        tick();
        f_read = 0;
        check("t5_dv_pop", 32'(f_dout_valid), 0);
        check("t5_empty", 32'(f_empty), 1);

        // 6: reset overrides traffic with level 5 and a sticky error pending
        read = 1;
        tick();
        read = 0;
        check("t6_unf_pre", 32'(underflow), 1);
        for (int i = 0; i < 5; i++) begin
            write = 1; din = 8'(8'h50 + i);
            tick();
        end
        write = 0; read = 1;
        tick();
        read = 0;
        check("t6_dout_pre", 32'(dout), 32'h50);
        write = 1; din = 8'h55;
        tick();
        check("t6_level_pre", 32'(level), 5);
        rst = 1; write = 1; read = 1;
        tick();
        rst = 0; write = 0; read = 0;
        check("t6_level", 32'(level), 0);
        check("t6_empty", 32'(fifo_empty), 1);
        check("t6_dout", 32'(dout), 0);
        check("t6_dv", 32'(dout_valid), 0);
        check("t6_errs", 32'({overflow, underflow}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
